// File: rtl/adc_sampler_pkg.sv
// Shared types and widths for the dual-channel SPI ADC sampler.
package adc_sampler_pkg;

  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_BITS  = 4;
  localparam int unsigned CNT_BITS   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    QUIET   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADC_BITS-1:0] i;
    logic [ADC_BITS-1:0] v;
  } sample_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: idles high, runs 16 periods of 2*CLK_DIV cycles while enabled,
// and reports rise/fall/done strobes in the cycle the new SCLK level appears.
module adc_sclk_gen
  import adc_sampler_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic done
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_BITS-1:0] RISE_LAST = CNT_BITS'(FRAME_BITS - 1);
  localparam logic [CNT_BITS-1:0] RISE_ALL  = CNT_BITS'(FRAME_BITS);

  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_BITS-1:0] rise_cnt;

  // Toggling stops once all rising edges are issued so SCLK parks high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk     <= 1'b1;
      div_cnt  <= '0;
      rise_cnt <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      done     <= 1'b0;
    end else if (!enable) begin
      sclk     <= 1'b1;
      div_cnt  <= '0;
      rise_cnt <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      done <= 1'b0;
      if (rise_cnt != RISE_ALL) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          sclk    <= ~sclk;
          if (sclk) begin
            fall <= 1'b1;
          end else begin
            rise     <= 1'b1;
            rise_cnt <= rise_cnt + CNT_BITS'(1);
            done     <= (rise_cnt == RISE_LAST);
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_dual_sampler.sv
// Runs one simultaneous 16-bit SPI frame on the current and voltage ADCs per
// START_ADC rising edge. Optional leading-zero check: ADC_LEADZERO_CHECK_EN.
module adc_dual_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned QUIET_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START_ADC,
  input  logic                ADC_SDATA_I,
  input  logic                ADC_SDATA_V,
  output logic                ADC_CS_N,
  output logic                ADC_SCLK,
  output logic [ADC_BITS-1:0] I,
  output logic [ADC_BITS-1:0] V,
  output logic                EOC,
  output logic                BUSY,
  output logic                FRAME_ERR
);

  localparam int unsigned Q_W = $clog2(QUIET_CYCLES) + 1;
  localparam logic [Q_W-1:0] Q_LAST = Q_W'(QUIET_CYCLES - 1);

  // Only the bits that are ever read back are stored between shifts.
`ifdef ADC_LEADZERO_CHECK_EN
  localparam int unsigned HIST_BITS = FRAME_BITS - 1;
`else
  localparam int unsigned HIST_BITS = ADC_BITS - 1;
`endif

  state_t state, state_d;
  logic   start_q, req;
  logic   pend, pend_d;
  logic   [Q_W-1:0] q_cnt, q_cnt_d;
  logic   [HIST_BITS-1:0] shift_i, shift_v;
  logic   [HIST_BITS:0]   frame_i, frame_v;
  logic   sclk_en, sclk_rise, sclk_fall, sclk_done, sclk_seen, capture;
  sample_t sample;

  assign req     = START_ADC & ~start_q;
  assign sclk_en = (state == CONVERT);
  assign capture = (state == CONVERT) & sclk_done;
  assign frame_i = {shift_i, ADC_SDATA_I};
  assign frame_v = {shift_v, ADC_SDATA_V};
  assign I       = sample.i;
  assign V       = sample.v;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (CLK),
    .rst    (RST),
    .enable (sclk_en),
    .sclk   (ADC_SCLK),
    .rise   (sclk_rise),
    .fall   (sclk_fall),
    .done   (sclk_done)
  );

  // Next-state and pending-request logic.
  always_comb begin
    state_d = state;
    pend_d  = pend;
    q_cnt_d = q_cnt;
    case (state)
      IDLE: begin
        if (req) state_d = CONVERT;
      end
      CONVERT: begin
        if (req) pend_d = 1'b1;
        if (sclk_done) begin
          state_d = QUIET;
          q_cnt_d = '0;
        end
      end
      QUIET: begin
        if (q_cnt == Q_LAST) begin
          if (pend || req) begin
            state_d = CONVERT;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          q_cnt_d = q_cnt + Q_W'(1);
          if (req) pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      pend      <= 1'b0;
      q_cnt     <= '0;
      shift_i   <= '0;
      shift_v   <= '0;
      sclk_seen <= 1'b0;
      sample    <= '0;
      ADC_CS_N  <= 1'b1;
      BUSY      <= 1'b0;
      EOC       <= 1'b0;
    end else begin
      state     <= state_d;
      start_q   <= START_ADC;
      pend      <= pend_d;
      q_cnt     <= q_cnt_d;
      ADC_CS_N  <= (state_d != CONVERT);
      BUSY      <= (state_d != IDLE);
      EOC       <= capture;
      // A rising edge is only meaningful once the ADC has driven a bit on a fall.
      sclk_seen <= sclk_en & (sclk_seen | sclk_fall);
      if (sclk_rise && sclk_seen) begin
        shift_i <= frame_i[HIST_BITS-1:0];
        shift_v <= frame_v[HIST_BITS-1:0];
      end
      if (capture) begin
        sample <= '{i: frame_i[ADC_BITS-1:0], v: frame_v[ADC_BITS-1:0]};
      end
    end
  end

`ifdef ADC_LEADZERO_CHECK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FRAME_ERR <= 1'b0;
    end else if (capture) begin
      FRAME_ERR <= (|frame_i[FRAME_BITS-1 -: LEAD_BITS]) | (|frame_v[FRAME_BITS-1 -: LEAD_BITS]);
    end
  end
`else
  assign FRAME_ERR = 1'b0;
`endif

endmodule
